// File: rtl/clk_div_monitor.sv
// Measures period and high time of an asynchronous divided clock in i_clk cycles,
// tracks lock over consecutive consistent measurements and flags missing edges.
module clk_div_monitor #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_N      = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_sig,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high,
  output logic             o_valid,
  output logic             o_locked,
  output logic             o_timeout
);

  localparam int unsigned MATCH_W = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [MATCH_W-1:0] LOCK_VAL = MATCH_W'(LOCK_N);
  localparam logic [MATCH_W-1:0] MATCH_ONE = MATCH_W'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_FALL = 2'd1,
    WAIT_RISE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 hist_q;
  logic                 synced, rise, fall;
  logic [CNT_W-1:0]     period_q, period_d;
  logic [CNT_W-1:0]     high_q, high_d;
  logic [CNT_W-1:0]     pend_q, pend_d;
  logic [MATCH_W-1:0]   match_q, match_d;
  logic [CNT_W-1:0]     period_out_d, high_out_d;
  logic                 valid_d, locked_d, timeout_d;
  logic [CNT_W-1:0]     high_diff;
  logic                 high_close;

  // Synchronizer and history flop keep sampling regardless of i_en.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= SYNC_STAGES'({sync_q, i_sig});
      hist_q <= synced;
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];
  assign rise   = synced & ~hist_q;
  assign fall   = ~synced & hist_q;

  assign high_diff  = (pend_q >= o_high) ? (pend_q - o_high) : (o_high - pend_q);
  assign high_close = (high_diff <= CNT_ONE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      period_q  <= '0;
      high_q    <= '0;
      pend_q    <= '0;
      match_q   <= '0;
      o_period  <= '0;
      o_high    <= '0;
      o_valid   <= 1'b0;
      o_locked  <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      high_q    <= high_d;
      pend_q    <= pend_d;
      match_q   <= match_d;
      o_period  <= period_out_d;
      o_high    <= high_out_d;
      o_valid   <= valid_d;
      o_locked  <= locked_d;
      o_timeout <= timeout_d;
    end
  end

  // Next-state, counters and registered-output next values.
  always_comb begin
    state_d      = state_q;
    period_d     = period_q;
    high_d       = high_q;
    pend_d       = pend_q;
    match_d      = match_q;
    period_out_d = o_period;
    high_out_d   = o_high;
    valid_d      = 1'b0;
    locked_d     = o_locked;
    timeout_d    = o_timeout;

    if (!i_en) begin
      state_d   = IDLE;
      period_d  = '0;
      high_d    = '0;
      pend_d    = '0;
      match_d   = '0;
      locked_d  = 1'b0;
      timeout_d = 1'b0;
    end else if (rise) begin
      // Rise beats a coincident timeout.
      period_d = CNT_ONE;
      high_d   = CNT_ONE;
      case (state_q)
        IDLE:      state_d = WAIT_FALL;
        WAIT_FALL: state_d = WAIT_FALL;
        WAIT_RISE: begin
          state_d      = WAIT_FALL;
          period_out_d = period_q;
          high_out_d   = pend_q;
          valid_d      = 1'b1;
          timeout_d    = 1'b0;
          if (match_q == '0) begin
            match_d = MATCH_ONE;
          end else if ((period_q == o_period) && high_close) begin
            match_d = (match_q < LOCK_VAL) ? (match_q + MATCH_ONE) : LOCK_VAL;
          end else begin
            match_d = MATCH_ONE;
          end
          locked_d = (match_d == LOCK_VAL);
        end
        default:   state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (period_q == CNT_MAX) begin
        state_d   = IDLE;
        period_d  = '0;
        high_d    = '0;
        pend_d    = '0;
        match_d   = '0;
        locked_d  = 1'b0;
        timeout_d = 1'b1;
      end else begin
        period_d = period_q + CNT_ONE;
        if (synced) begin
          high_d = high_q + CNT_ONE;
        end
        // A fall seen while waiting for a rise is ignored.
        if ((state_q == WAIT_FALL) && fall) begin
          pend_d  = high_q;
          state_d = WAIT_RISE;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Table-driven bench for clk_div_monitor: waveform rows drive i_sig, a scoreboard
// queue holds expected measurements that are popped on every o_valid.
module tb_clk_div_monitor;

  localparam int CNT_W  = 8;
  localparam int LOCK_N = 4;

  logic             clk = 1'b0;
  logic             rst, en, sig;
  logic [CNT_W-1:0] o_period, o_high;
  logic             o_valid, o_locked, o_timeout;

  always #5 clk = ~clk;

  clk_div_monitor #(.CNT_W(CNT_W), .SYNC_STAGES(2), .LOCK_N(LOCK_N)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_en     (en),
    .i_sig    (sig),
    .o_period (o_period),
    .o_high   (o_high),
    .o_valid  (o_valid),
    .o_locked (o_locked),
    .o_timeout(o_timeout)
  );

  typedef struct {
    int high;
    int low;
    int exp_period;
    int exp_high;
  } vec_t;

  typedef struct {
    int period;
    int high;
    int locked;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference lock model and the period currently awaiting its closing rise.
  int m_cnt = 0, m_prev_p = 0, m_prev_h = 0;
  bit primed = 1'b0;
  int pend_p = 0, pend_h = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int p, input int h);
    exp_t e;
    int   d;
    d = (h > m_prev_h) ? (h - m_prev_h) : (m_prev_h - h);
    if (m_cnt == 0) m_cnt = 1;
    else if (p == m_prev_p && d <= 1) m_cnt = (m_cnt < LOCK_N) ? m_cnt + 1 : LOCK_N;
    else m_cnt = 1;
    m_prev_p = p;
    m_prev_h = h;
    e.period = p;
    e.high   = h;
    e.locked = (m_cnt == LOCK_N) ? 1 : 0;
    sbq.push_back(e);
  endtask

  // Starting a new high phase closes the previous period.
  task automatic drive_period(input int h, input int l, input int ep, input int eh);
    if (primed) push_exp(pend_p, pend_h);
    pend_p = ep;
    pend_h = eh;
    primed = 1'b1;
    sig = 1'b1;
    repeat (h) tick();
    sig = 1'b0;
    repeat (l) tick();
  endtask

  task automatic model_idle();
    primed = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic add_rows(input int h, input int l, input int ep, input int eh, input int n);
    vec_t v;
    v.high = h; v.low = l; v.exp_period = ep; v.exp_high = eh;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_valid actual=valid expected=none period=%0d high=%0d at %0t",
                 o_period, o_high, $time);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("valid_period", int'(o_period), e.period);
        check("valid_high", int'(o_high), e.high);
        check("valid_locked", int'(o_locked), e.locked);
        check("valid_timeout", int'(o_timeout), 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    // Alternating 3/4 from reset, steady 4/3, divide-by-4, minimum period, back to 7.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) add_rows(3, 4, 7, 3, 1);
      else            add_rows(4, 3, 7, 4, 1);
    end
    add_rows(4, 3, 7, 4, 4);
    add_rows(2, 2, 4, 2, 6);
    add_rows(1, 1, 2, 1, 5);
    add_rows(4, 3, 7, 4, 6);

    rst = 1'b1; en = 1'b1; sig = 1'b0;
    repeat (3) tick();
    check("rst_period", int'(o_period), 0);
    check("rst_high", int'(o_high), 0);
    check("rst_valid", int'(o_valid), 0);
    check("rst_locked", int'(o_locked), 0);
    check("rst_timeout", int'(o_timeout), 0);
    rst = 1'b0;
    repeat (2) tick();

    foreach (vecs[i]) drive_period(vecs[i].high, vecs[i].low, vecs[i].exp_period, vecs[i].exp_high);
    check("locked_before_timeout", int'(o_locked), 1);

    // Hold i_sig low until the period counter saturates.
    model_idle();
    w = 0;
    while (o_timeout !== 1'b1 && w < 400) begin
      tick();
      w++;
    end
    check("timeout_seen", int'(o_timeout), 1);
    n_checks++;
    if (w < 245 || w > 257) begin
      n_errors++;
      $display("FAIL timeout_latency actual=%0d expected=245..257", w);
    end
    check("timeout_unlocked", int'(o_locked), 0);
    check("timeout_period_held", int'(o_period), 7);
    check("timeout_high_held", int'(o_high), 4);
    drive_period(4, 3, 7, 4);
    check("timeout_kept_after_prime", int'(o_timeout), 1);
    drive_period(4, 3, 7, 4);
    check("timeout_cleared", int'(o_timeout), 0);
    for (int i = 0; i < 4; i++) drive_period(4, 3, 7, 4);

    // Reset pulse while waiting for the closing rise.
    drive_period(4, 3, 7, 4);
    rst = 1'b1;
    tick();
    check("midrst_period", int'(o_period), 0);
    check("midrst_high", int'(o_high), 0);
    check("midrst_valid", int'(o_valid), 0);
    check("midrst_locked", int'(o_locked), 0);
    check("midrst_timeout", int'(o_timeout), 0);
    rst = 1'b0;
    model_idle();
    for (int i = 0; i < 6; i++) drive_period(4, 3, 7, 4);
    check("relock_after_rst", int'(o_locked), 1);

    // Enable dropped for three cycles while locked.
    en = 1'b0;
    tick();
    check("en_low_locked", int'(o_locked), 0);
    check("en_low_valid", int'(o_valid), 0);
    check("en_low_period_held", int'(o_period), 7);
    repeat (2) tick();
    en = 1'b1;
    model_idle();
    for (int i = 0; i < 4; i++) drive_period(4, 3, 7, 4);
    check("en_not_yet_locked", int'(o_locked), 0);
    drive_period(4, 3, 7, 4);
    check("en_relock", int'(o_locked), 1);

    repeat (5) tick();
    check("scoreboard_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/clk_div_monitor.md
CLK_DIV_MONITOR -- requirements
Module: clk_div_monitor

Interface
REQ-001 Parameter CNT_W, default 8: width of the period and high-time counters, in i_clk cycles.
REQ-002 Parameter SYNC_STAGES, default 2: number of synchronizer flops on i_sig.
REQ-003 Parameter LOCK_N, default 4: number of consecutive matching measurements required to assert lock.
REQ-004 i_clk  input  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-005 i_rst  input  1  reset, synchronous and active-high.
REQ-006 i_en  input  1  measurement enable; low SHALL force the idle state.
REQ-007 i_sig  input  1  divided clock under measurement, treated as asynchronous data.
REQ-008 o_period  output  CNT_W  last measured rise-to-rise period, in i_clk cycles.
REQ-009 o_high  output  CNT_W  last measured high time, in i_clk cycles.
REQ-010 o_valid  output  1  one-cycle pulse when o_period and o_high update.
REQ-011 o_locked  output  1  LOCK_N consecutive consistent measurements have been seen.
REQ-012 o_timeout  output  1  no rising edge of i_sig within 2^CNT_W-1 cycles.

Function
REQ-013 i_sig SHALL pass through SYNC_STAGES flops, followed by one history flop.
- rise = synced & ~history.
- fall = ~synced & history.
REQ-014 The FSM SHALL have three states: IDLE, WAIT_FALL and WAIT_RISE.
- IDLE -> WAIT_FALL on the first rise.
- WAIT_FALL -> WAIT_RISE on fall.
- WAIT_RISE -> WAIT_FALL on rise.
REQ-015 On every rise, the period counter SHALL load 1; on every other cycle outside IDLE it SHALL increment by 1.
REQ-016 On every rise, the high counter SHALL load 1; on other cycles it SHALL increment while the synced level is 1.
REQ-017 On fall in WAIT_FALL, the high counter value SHALL be captured into a pending-high register.
REQ-018 On rise in WAIT_RISE, the block SHALL register o_period = period counter and o_high = pending-high, and pulse o_valid for one cycle.
REQ-019 The first rise after IDLE SHALL NOT produce o_valid, because the counters are not yet primed.
REQ-020 Latency: o_valid SHALL assert SYNC_STAGES cycles after the i_clk edge at which i_sig is first sampled high for the closing rising edge.
REQ-021 Measurements SHALL be quantized to whole i_clk cycles.
- A 50%-duty odd-ratio input of period P may report o_high of floor(P/2) or ceil(P/2).
- Both values SHALL be accepted as valid.
REQ-022 The minimum measurable period SHALL be 2; a shorter input pulse that is lost by sampling is out of scope.
REQ-023 Lock tracking:
- A match counter SHALL count consecutive o_valid events whose o_period equals the previous o_period and whose o_high differs from the previous o_high by at most 1.
- The first o_valid after IDLE SHALL set the match counter to 1.
REQ-024 o_locked SHALL assert in the same cycle that the match counter reaches LOCK_N, and the match counter SHALL saturate at LOCK_N.
REQ-025 On a mismatching o_valid, the match counter SHALL load 1 and o_locked SHALL deassert in the same cycle as that o_valid.
REQ-026 Timeout: if the period counter reaches 2^CNT_W-1 outside IDLE without a rise, the block SHALL set o_timeout and enter IDLE.
- o_locked SHALL clear and the match counter SHALL clear.
- o_period and o_high SHALL hold their last values.
- The period counter SHALL NOT wrap.
REQ-027 o_timeout SHALL remain high until the next o_valid, i_rst, or i_en low.
REQ-028 If i_en is low, the block SHALL enter IDLE on the next edge.
- Counters, match counter, o_locked, o_valid and o_timeout SHALL clear.
- o_period and o_high SHALL hold their last values.
- The synchronizer SHALL keep sampling.
REQ-029 If rise and timeout occur in the same cycle, rise SHALL take priority and no timeout SHALL occur.
REQ-030 If a fall occurs in WAIT_RISE, it SHALL be ignored, since it cannot occur with a consistent synchronizer.

Reset
REQ-031 When i_rst is high at a rising edge of i_clk, the following SHALL be 0:
- all synchronizer flops and the history flop;
- the FSM (IDLE);
- the period, high, match and pending-high counters;
- o_period, o_high, o_valid, o_locked and o_timeout.
REQ-032 i_rst SHALL take priority over i_en and over every in-progress measurement.
REQ-033 The first rise after reset release SHALL only prime the counters (REQ-019).

Verification
REQ-034 Divide-by-7, high 4 / low 3, i_clk-synchronous -> o_period=7, o_high=4 on each o_valid; o_locked high at the 4th o_valid.
REQ-035 Divide-by-7, alternating high 3/4 -> every o_period=7; o_locked still asserts at the 4th o_valid (±1 tolerance).
REQ-036 Locked at period 7, switched to divide-by-4 (2/2) -> the first o_valid shows 4/2 with o_locked=0; o_locked returns at the 4th consecutive 4/2 measurement.
REQ-037 Locked, then i_sig held at 0 -> o_timeout=1 and o_locked=0 within 255 cycles of the last rise; o_period=7 held; o_timeout clears at the next o_valid after i_sig resumes toggling.
REQ-038 i_rst pulsed mid-WAIT_RISE -> all outputs 0 on the next cycle; the first rise after release gives no o_valid; the second rise gives a correct o_valid.
REQ-039 i_en dropped for 3 cycles while locked -> o_locked=0 and o_valid=0 with o_period held; after i_en returns, lock is re-acquired after 1+LOCK_N rises.
